stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-input, WIDTH-bit streaming multiplexer that replaces the combinational 2:1 mux where sources are independent valid/ready streams. A round-robin arbiter picks among requesting inputs and forwards the winning beat into a single registered output stage. An optional packet mode holds the grant on one input until that input's last beat. The block sits between multiple producer streams and one shared consumer.

## Interface
- NUM_INPUTS, 4, number of input channels (≥1)
- WIDTH, 8, data width in bits (≥1)
- PACKET_MODE, 0, 0 = arbitrate every beat; 1 = hold grant until in_last beat accepted
- SEL_WIDTH, derived, $clog2(NUM_INPUTS) with a minimum of 1; not overridable

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  NUM_INPUTS  per-channel beat available
- in_ready  output  NUM_INPUTS  per-channel beat accepted this cycle (combinational)
- in_data  input  NUM_INPUTS×WIDTH  per-channel data, unpacked array [NUM_INPUTS][WIDTH]
- in_last  input  NUM_INPUTS  per-channel end-of-packet flag
- out_valid  output  1  registered beat available
- out_ready  input  1  consumer accepts out beat
- out_data  output  WIDTH  registered data
- out_last  output  1  registered last flag
- out_sel  output  SEL_WIDTH  index of the input that supplied the current out beat

## Operation
- load = (!out_valid || out_ready) && |eligible. Eligible = in_valid masked by the lock owner in LOCKED, else all in_valid.
- Grant is one-hot. Round-robin search starts at (last_grant+1) mod NUM_INPUTS and takes the first eligible index.
- in_ready[i] = load && grant[i]. At most one bit is high. All bits are 0 when the output is stalled (out_valid && !out_ready).
- On load: out_data/out_last/out_sel ← granted channel; out_valid ← 1; last_grant ← granted index.
- On out_valid && out_ready && !load: out_valid ← 0. Data registers hold their value.
- Throughput is 1 beat/cycle with continuous out_ready (no bubble on simultaneous drain and load).
- FSM (PACKET_MODE=1 only; with PACKET_MODE=0 the FSM stays in ARB and in_last is only forwarded):
  - ARB → LOCKED on a load with in_last=0; owner ← granted index.
  - ARB stays in ARB on a load with in_last=1 (single-beat packet).
  - LOCKED: only the owner is eligible. Other inputs see in_ready=0 even if the owner is idle.
  - LOCKED → ARB on a load with in_last=1 from the owner; last_grant ← owner.
- Sources follow the valid/ready rule: hold data until accepted. The block does not rely on it; an unaccepted withdrawn beat is simply never granted.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, out_sel=0, state=ARB, last_grant=NUM_INPUTS-1 (input 0 has top priority first), owner=0. in_ready=0 while rst is high.
- Latency: a beat accepted at edge k appears on out_* immediately after edge k. It is valid through cycle k+1 and later while stalled.
- Stalled output: out_data/out_last/out_sel stay stable; last_grant and state are frozen.
- Wrap-around: last_grant = NUM_INPUTS-1 means the search starts at 0.
- NUM_INPUTS=1: grant = in_valid[0]; out_sel is always 0.
- Reset asserted mid-packet or with a pending out beat: the pending beat is discarded and the FSM returns to ARB immediately (asynchronous).

## Structure
- Package stream_mux_pkg holds the FSM state typedef (ARB, LOCKED) and a function computing SEL_WIDTH with a floor of 1.
- Sub-module rr_arbiter (parameter NUM_INPUTS):
  - inputs: req, last_grant, advance
  - output: one-hot grant plus encoded index
  - reusable by other stream blocks
- The top level holds the lock FSM, the output register and the handshake logic.

## Test plan
- Reset: assert rst mid-run with out_valid=1 → out_valid=0, out_data=0 and in_ready=0 in the same cycle, without waiting for a clock edge. After release, input 0 wins first.
- Round-robin fairness: NUM_INPUTS=4, all in_valid=1, out_ready=1, data=i → out_sel sequence 0,1,2,3,0,… with one beat every cycle and no bubbles.
- Backpressure: out_ready=0 for 5 cycles while inputs 1 and 2 request → out beat unchanged, in_ready=0. On release, input 2 is granted next if 1 was the last winner.
- Sparse requests: only in_valid[3]=1 then only in_valid[1]=1 → grants 3 then 1 with no idle-channel starvation; last_grant wraps correctly.
- Packet mode: PACKET_MODE=1, input 0 sends 3 beats (last on the 3rd) while input 1 requests → out_sel=0,0,0 then 1. in_ready[1] stays 0 during the packet, including a cycle when in_valid[0] drops.
- Scoreboard: random valid/ready on all channels for 10k cycles, compared against a reference model → every accepted beat appears exactly once, in per-channel order, with correct out_last.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    // Index width for n channels, never narrower than one bit
    function automatic int sel_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant wins.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    localparam int SEL_WIDTH = sel_width(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [SEL_WIDTH-1:0]  last_grant,
    input  logic                  advance,
    output logic [NUM_INPUTS-1:0] grant,
    output logic [SEL_WIDTH-1:0]  grant_idx
);

    logic found_s;
    int   cand_s;

    // Rotating priority search; grant stays zero unless the caller may advance
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        cand_s    = 0;
        for (int off = 0; off < NUM_INPUTS; off++) begin
            cand_s = (int'(last_grant) + 1 + off) % NUM_INPUTS;
            if (!found_s && advance && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                grant_idx     = SEL_WIDTH'(cand_s);
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-input valid/ready stream mux with round-robin arbitration, optional
// packet locking and a single registered output stage.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int WIDTH       = 8,
    parameter int PACKET_MODE = 0,
    localparam int SEL_WIDTH  = sel_width(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] in_valid,
    output logic [NUM_INPUTS-1:0] in_ready,
    input  logic [WIDTH-1:0]      in_data [NUM_INPUTS],
    input  logic [NUM_INPUTS-1:0] in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [SEL_WIDTH-1:0]  out_sel
);

    lock_state_t            state_r;
    logic [SEL_WIDTH-1:0]   owner_r;
    logic [SEL_WIDTH-1:0]   last_grant_r;
    logic                   out_valid_r;
    logic [WIDTH-1:0]       out_data_r;
    logic                   out_last_r;
    logic [SEL_WIDTH-1:0]   out_sel_r;

    logic [NUM_INPUTS-1:0]  owner_mask_s;
    logic [NUM_INPUTS-1:0]  eligible_s;
    logic                   can_load_s;
    logic                   load_s;
    logic [NUM_INPUTS-1:0]  grant_s;
    logic [SEL_WIDTH-1:0]   grant_idx_s;

    // While locked only the owner may compete, even when it has nothing to send
    always_comb begin
        owner_mask_s = NUM_INPUTS'(1) << owner_r;
        if (state_r == LOCKED) begin
            eligible_s = in_valid & owner_mask_s;
        end else begin
            eligible_s = in_valid;
        end
        can_load_s = (!out_valid_r || out_ready) && !rst;
        load_s     = can_load_s && (|eligible_s);
    end

    rr_arbiter #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_arb (
        .req        (eligible_s),
        .last_grant (last_grant_r),
        .advance    (can_load_s),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s)
    );

    assign in_ready  = grant_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign out_sel   = out_sel_r;

    // Output register, round-robin pointer and packet lock FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ARB;
            owner_r      <= '0;
            last_grant_r <= SEL_WIDTH'(NUM_INPUTS - 1);
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_last_r   <= 1'b0;
            out_sel_r    <= '0;
        end else if (load_s) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= in_data[grant_idx_s];
            out_last_r   <= in_last[grant_idx_s];
            out_sel_r    <= grant_idx_s;
            last_grant_r <= grant_idx_s;
            if (PACKET_MODE != 0) begin
                case (state_r)
                    ARB: begin
                        if (!in_last[grant_idx_s]) begin
                            state_r <= LOCKED;
                            owner_r <= grant_idx_s;
                        end else begin
                            state_r <= ARB;
                        end
                    end
                    LOCKED: begin
                        if (in_last[grant_idx_s]) begin
                            state_r <= ARB;
                        end else begin
                            state_r <= LOCKED;
                        end
                    end
                    default: state_r <= ARB;
                endcase
            end else begin
                state_r <= ARB;
            end
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed and scoreboard bench for stream_mux_rr in beat and packet modes.
module tb_stream_mux_rr;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic [N-1:0] v0, r0, l0;
    logic [W-1:0] d0 [N];
    logic         ov0, ord0, ol0;
    logic [W-1:0] od0;
    logic [1:0]   os0;

    logic [N-1:0] v1, r1, l1;
    logic [W-1:0] d1 [N];
    logic         ov1, ord1, ol1;
    logic [W-1:0] od1;
    logic [1:0]   os1;

    int total = 0;
    int bad   = 0;

    int           seq     [N];
    int           exp_seq [N];
    logic [N-1:0] acc;

    always #5 clk = ~clk;

    stream_mux_rr #(.NUM_INPUTS(N), .WIDTH(W), .PACKET_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(d0),
        .in_last(l0), .out_valid(ov0), .out_ready(ord0), .out_data(od0),
        .out_last(ol0), .out_sel(os0)
    );

    stream_mux_rr #(.NUM_INPUTS(N), .WIDTH(W), .PACKET_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1),
        .in_last(l1), .out_valid(ov1), .out_ready(ord1), .out_data(od1),
        .out_last(ol1), .out_sel(os1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mkdata(input int c, input int s);
        return W'(c * 64 + (s % 64));
    endfunction

    function automatic logic mklast(input int s);
        return (s % 3) == 2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        v0 = 4'hF; l0 = 4'h0; ord0 = 1'b1;
        v1 = 4'h0; l1 = 4'h0; ord1 = 1'b1;
        for (int i = 0; i < N; i++) begin
            d0[i] = 8'h10 + 8'(i);
            d1[i] = 8'h00;
        end

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ov", 32'(ov0), 32'd0);
        check_eq("rst_od", 32'(od0), 32'd0);
        check_eq("rst_ol", 32'(ol0), 32'd0);
        check_eq("rst_os", 32'(os0), 32'd0);
        check_eq("rst_rdy", 32'(r0), 32'd0);
        check_eq("rst_ov1", 32'(ov1), 32'd0);

        // fairness: all valid, continuous ready
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("first_rdy", 32'(r0), 32'h1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq("rr_sel", 32'(os0), 32'(k % 4));
            check_eq("rr_data", 32'(od0), 32'(8'h10 + 8'(k % 4)));
            check_eq("rr_valid", 32'(ov0), 32'd1);
            check_eq("rr_last", 32'(ol0), 32'd0);
            if (k < 5) check_eq("rr_rdy", 32'(r0), 32'(1 << ((k + 1) % 4)));
        end

        // backpressure with inputs 1 and 2 requesting, last winner 1
        ord0 = 1'b0; v0 = 4'b0110;
        #1;
        check_eq("bp_rdy0", 32'(r0), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("bp_ov", 32'(ov0), 32'd1);
            check_eq("bp_os", 32'(os0), 32'd1);
            check_eq("bp_od", 32'(od0), 32'h11);
            check_eq("bp_rdy", 32'(r0), 32'd0);
        end
        ord0 = 1'b1;
        #1;
        check_eq("bp_rel_rdy", 32'(r0), 32'b0100);
        tick();
        check_eq("bp_rel_os", 32'(os0), 32'd2);
        check_eq("bp_rel_od", 32'(od0), 32'h12);

        // sparse requests and pointer wrap
        v0 = 4'b1000;
        #1;
        check_eq("sp3_rdy", 32'(r0), 32'b1000);
        tick();
        check_eq("sp3_os", 32'(os0), 32'd3);
        v0 = 4'b0010;
        #1;
        check_eq("sp1_rdy", 32'(r0), 32'b0010);
        tick();
        check_eq("sp1_os", 32'(os0), 32'd1);
        v0 = 4'b0011;
        #1;
        check_eq("wrap_rdy", 32'(r0), 32'b0001);
        tick();
        check_eq("wrap_os", 32'(os0), 32'd0);
        check_eq("wrap_od", 32'(od0), 32'h10);
        v0 = 4'b0000;
        tick();
        check_eq("drain_ov", 32'(ov0), 32'd0);
        check_eq("drain_hold", 32'(od0), 32'h10);

        // asynchronous reset with a pending beat
        v0 = 4'hF;
        #1;
        check_eq("pre_rst_rdy", 32'(r0), 32'b0010);
        tick();
        check_eq("pre_rst_os", 32'(os0), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("arst_ov", 32'(ov0), 32'd0);
        check_eq("arst_od", 32'(od0), 32'd0);
        check_eq("arst_os", 32'(os0), 32'd0);
        check_eq("arst_rdy", 32'(r0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_rdy", 32'(r0), 32'h1);
        tick();
        check_eq("post_rst_os", 32'(os0), 32'd0);
        v0 = 4'h0;
        tick();

        // packet mode: input 0 sends 3 beats while input 1 waits
        v1 = 4'b0011; l1 = 4'b0010;
        d1[0] = 8'hA0; d1[1] = 8'hB0;
        #1;
        check_eq("pk_rdy0", 32'(r1), 32'b0001);
        tick();
        check_eq("pk_os0", 32'(os1), 32'd0);
        check_eq("pk_od0", 32'(od1), 32'hA0);
        d1[0] = 8'hA1;
        #1;
        check_eq("pk_rdy1", 32'(r1), 32'b0001);
        tick();
        check_eq("pk_os1", 32'(os1), 32'd0);
        check_eq("pk_od1", 32'(od1), 32'hA1);
        v1 = 4'b0010;
        #1;
        check_eq("pk_idle_rdy", 32'(r1), 32'd0);
        tick();
        check_eq("pk_idle_ov", 32'(ov1), 32'd0);
        check_eq("pk_idle_rdy2", 32'(r1), 32'd0);
        v1 = 4'b0011; d1[0] = 8'hA2; l1 = 4'b0011;
        #1;
        check_eq("pk_rdy2", 32'(r1), 32'b0001);
        tick();
        check_eq("pk_os2", 32'(os1), 32'd0);
        check_eq("pk_od2", 32'(od1), 32'hA2);
        check_eq("pk_ol2", 32'(ol1), 32'd1);
        check_eq("pk_next_rdy", 32'(r1), 32'b0010);
        tick();
        check_eq("pk_os_b", 32'(os1), 32'd1);
        check_eq("pk_od_b", 32'(od1), 32'hB0);
        v1 = 4'b0000;
        tick();

        // scoreboard: random valid/ready, per-channel ordered sequences
        for (int c = 0; c < N; c++) begin
            seq[c] = 0;
            exp_seq[c] = 0;
        end
        v0 = '0;
        acc = '0;
        for (int cyc = 0; cyc < 10003; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (acc[c]) seq[c]++;
                if (cyc >= 10000) begin
                    v0[c] = 1'b0;
                end else if (!(v0[c] && !acc[c])) begin
                    v0[c] = ($urandom_range(0, 2) != 0);
                end
                d0[c] = mkdata(c, seq[c]);
                l0[c] = mklast(seq[c]);
            end
            ord0 = (cyc >= 10000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            check_eq("sb_onehot", 32'($countones(r0) <= 1), 32'd1);
            if (ov0 && !ord0) check_eq("sb_stall_rdy", 32'(r0), 32'd0);
            if ((!ov0 || ord0) && (|v0)) check_eq("sb_any_rdy", 32'(|r0), 32'd1);
            acc = v0 & r0;
            if (ov0 && ord0) begin
                check_eq("sb_data", 32'(od0), 32'(mkdata(int'(os0), exp_seq[os0])));
                check_eq("sb_last", 32'(ol0), 32'(mklast(exp_seq[os0])));
                exp_seq[os0]++;
            end
            tick();
        end
        for (int c = 0; c < N; c++) begin
            if (acc[c]) seq[c]++;
        end
        check_eq("sb_final_ov", 32'(ov0), 32'd0);
        for (int c = 0; c < N; c++) begin
            check_eq("sb_count", 32'(exp_seq[c]), 32'(seq[c]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
